fetch_unit: RTL and testbench

Instruction-fetch stage of the RV32I core. Holds the program counter, issues one-outstanding requests to instruction memory, and buffers the returned word for decode. It sits downstream of the branch-resolution logic: it consumes the `pcjump` redirect and computes the jump target. It also kills any wrong-path fetch in flight.

---
 rtl/fetch_unit.sv | 146 ++++++++++++++
 tb/tb_fetch_unit.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch: holds the PC, issues one outstanding imem request, buffers one word for decode.
// Latency: accept at N, rvalid at N+1, if_valid at N+2; decode stalls hold the buffer and block new requests.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pcjump,
    input  logic        jalr,
    input  logic [31:0] ex_pc,
    input  logic [31:0] rs1data,
    input  logic [31:0] imm,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    input  logic        id_ready,
    output logic        misaligned,
    output logic [31:0] badaddr
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_t;

    state_t      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] pend_pc_q, pend_pc_d;
    logic        kill_q, kill_d;
    logic        if_valid_q, if_valid_d;
    logic [31:0] if_instr_q, if_instr_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic        misaligned_q, misaligned_d;
    logic [31:0] badaddr_q, badaddr_d;
    logic        req_q;

    logic [31:0] sum;
    logic [31:0] tgt;
    logic        jump_ok;
    logic        jump_bad;

    always_comb begin
        sum      = (jalr ? rs1data : ex_pc) + imm;
        tgt      = {sum[31:1], sum[0] & ~jalr};
        jump_ok  = pcjump & ~tgt[1];
        jump_bad = pcjump & tgt[1];
    end

    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        pend_pc_d    = pend_pc_q;
        kill_d       = kill_q;
        if_valid_d   = if_valid_q;
        if_instr_d   = if_instr_q;
        if_pc_d      = if_pc_q;
        misaligned_d = jump_bad;
        badaddr_d    = jump_bad ? tgt : badaddr_q;
        case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
                if (jump_ok) fetch_pc_d = tgt;
            end
            S_REQ: begin
                // An unaccepted request keeps its address; the redirect lands via kill/pend_pc.
                if (imem_ready) state_d = S_WAIT;
                if (jump_ok) begin
                    pend_pc_d = tgt;
                    kill_d    = 1'b1;
                end
            end
            S_WAIT: begin
                if (jump_ok) begin
                    pend_pc_d = tgt;
                    if (imem_rvalid) begin
                        fetch_pc_d = tgt;
                        kill_d     = 1'b0;
                        state_d    = S_REQ;
                    end else begin
                        kill_d = 1'b1;
                    end
                end else if (imem_rvalid) begin
                    if (kill_q) begin
                        fetch_pc_d = pend_pc_q;
                        kill_d     = 1'b0;
                        state_d    = S_REQ;
                    end else begin
                        if_instr_d = imem_rdata;
                        if_pc_d    = fetch_pc_q;
                        if_valid_d = 1'b1;
                        fetch_pc_d = fetch_pc_q + 32'd4;
                        state_d    = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (jump_ok) begin
                    if_valid_d = 1'b0;
                    fetch_pc_d = tgt;
                    state_d    = S_REQ;
                end else if (if_valid_q && id_ready) begin
                    if_valid_d = 1'b0;
                    state_d    = S_REQ;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            fetch_pc_q   <= RESET_PC;
            pend_pc_q    <= 32'h0;
            kill_q       <= 1'b0;
            if_valid_q   <= 1'b0;
            if_instr_q   <= 32'h0;
            if_pc_q      <= 32'h0;
            misaligned_q <= 1'b0;
            badaddr_q    <= 32'h0;
            req_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            pend_pc_q    <= pend_pc_d;
            kill_q       <= kill_d;
            if_valid_q   <= if_valid_d;
            if_instr_q   <= if_instr_d;
            if_pc_q      <= if_pc_d;
            misaligned_q <= misaligned_d;
            badaddr_q    <= badaddr_d;
            req_q        <= (state_d == S_REQ);
        end
    end

    assign imem_req   = req_q;
    assign imem_addr  = fetch_pc_q;
    assign if_valid   = if_valid_q;
    assign if_instr   = if_instr_q;
    assign if_pc      = if_pc_q;
    assign misaligned = misaligned_q;
    assign badaddr    = badaddr_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed sequences, a redirect vector table and a randomized run against a stream model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pcjump, jalr;
    logic [31:0] ex_pc, rs1data, imm;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready, imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_instr, if_pc;
    logic        id_ready;
    logic        misaligned;
    logic [31:0] badaddr;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(32'h100)) dut (
        .clk(clk), .rst_n(rst_n), .pcjump(pcjump), .jalr(jalr), .ex_pc(ex_pc),
        .rs1data(rs1data), .imm(imm), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .id_ready(id_ready),
        .misaligned(misaligned), .badaddr(badaddr)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // memory model state
    int          mem_cnt   = -1;
    logic [31:0] mem_addr  = 32'h0;
    int          lat_max   = 0;
    int          ready_pct = 100;
    bit          fixed_data = 1'b1;

    typedef struct {
        logic        jalr;
        logic [31:0] ex_pc;
        logic [31:0] rs1;
        logic [31:0] imm;
        logic [31:0] exp_tgt;
        logic        exp_mis;
    } vec_t;

    vec_t vecs[8];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return fixed_data ? 32'h0000_0013 : ((a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F);
    endfunction

    function automatic logic [31:0] ref_tgt(input logic j, input logic [31:0] pc,
                                            input logic [31:0] r, input logic [31:0] im);
        logic [31:0] t;
        t = (j ? r : pc) + im;
        if (j) t = t & 32'hFFFF_FFFE;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timeout", name);
    endtask

    task automatic tick();
        logic        acc;
        logic [31:0] aa;
        acc = imem_req && imem_ready;
        aa  = imem_addr;
        @(posedge clk);
        #1;
        imem_rvalid = 1'b0;
        if (acc) begin
            mem_cnt  = (lat_max == 0) ? 0 : int'($urandom_range(lat_max, 0));
            mem_addr = aa;
        end
        if (mem_cnt == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(mem_addr);
            mem_cnt     = -1;
        end else if (mem_cnt > 0) begin
            mem_cnt--;
        end
        imem_ready = ($urandom_range(99, 0) < ready_pct);
    endtask

    task automatic wait_valid(input string name);
        int k = 0;
        while (!if_valid && k < 60) begin
            tick();
            k++;
        end
        if (!if_valid) timeout(name);
    endtask

    task automatic assert_reset();
        rst_n = 1'b0;
        pcjump = 1'b0; jalr = 1'b0; ex_pc = 32'h0; rs1data = 32'h0; imm = 32'h0;
        imem_rvalid = 1'b0; imem_rdata = 32'h0;
        imem_ready = (ready_pct > 0);
        mem_cnt = -1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic release_reset();
        rst_n = 1'b1;
        check("post-release req", imem_req, 1'b0);
        tick();
        check("first req", imem_req, 1'b1);
        check("first addr", imem_addr, 32'h100);
    endtask

    initial begin
        logic [31:0] p, ins, nxt, exp_pc, hold_addr, t;
        logic        exp_mis, chk;
        int          cyc, last, seen, delivered;

        vecs[0] = '{1'b0, 32'h0000_0040, 32'h0000_0000, 32'h0000_0040, 32'h0000_0080, 1'b0};
        vecs[1] = '{1'b1, 32'h0000_0000, 32'h0000_0303, 32'h0000_0000, 32'h0000_0302, 1'b1};
        vecs[2] = '{1'b1, 32'h0000_5000, 32'h0000_1001, 32'h0000_0003, 32'h0000_1004, 1'b0};
        vecs[3] = '{1'b0, 32'h0000_1000, 32'h0000_0000, 32'hFFFF_FFF0, 32'h0000_0FF0, 1'b0};
        vecs[4] = '{1'b0, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0008, 32'h0000_0004, 1'b0};
        vecs[5] = '{1'b0, 32'h0000_0100, 32'h0000_0000, 32'h0000_0006, 32'h0000_0106, 1'b1};
        vecs[6] = '{1'b1, 32'h0000_0000, 32'h0000_2000, 32'h0000_0007, 32'h0000_2006, 1'b1};
        vecs[7] = '{1'b0, 32'h0000_3000, 32'h0000_FFFF, 32'h0000_0020, 32'h0000_3020, 1'b0};

        // reset values and sequential fetch with zero-wait memory
        id_ready = 1'b1;
        assert_reset();
        check("rst req", imem_req, 1'b0);
        check("rst addr", imem_addr, 32'h100);
        check("rst if_valid", if_valid, 1'b0);
        check("rst if_instr", if_instr, 32'h0);
        check("rst if_pc", if_pc, 32'h0);
        check("rst misaligned", misaligned, 1'b0);
        check("rst badaddr", badaddr, 32'h0);
        release_reset();
        cyc = 0; last = 0; seen = 0; exp_pc = 32'h100;
        while (seen < 3 && cyc < 40) begin
            if (if_valid) begin
                check("seq if_pc", if_pc, exp_pc);
                check("seq if_instr", if_instr, 32'h13);
                if (seen > 0) check("seq spacing", cyc - last, 3);
                last = cyc;
                seen++;
                exp_pc += 4;
            end
            tick();
            cyc++;
        end
        if (seen < 3) timeout("seq pulses");

        // stalled request with a redirect landing while unaccepted
        ready_pct = 0;
        assert_reset();
        release_reset();
        for (int c = 1; c <= 4; c++) begin
            if (c == 2) begin
                pcjump = 1'b1; jalr = 1'b0; ex_pc = 32'h200; imm = 32'h40;
            end
            tick();
            pcjump = 1'b0;
            check("stall req", imem_req, 1'b1);
            check("stall addr", imem_addr, 32'h100);
        end
        ready_pct = 100;
        imem_ready = 1'b1;
        tick();
        check("killed wait req", imem_req, 1'b0);
        tick();
        check("killed no valid", if_valid, 1'b0);
        check("redirect req", imem_req, 1'b1);
        check("redirect addr", imem_addr, 32'h240);
        wait_valid("redirect fetch");
        check("redirect if_pc", if_pc, 32'h240);

        // redirect in WAIT coinciding with rvalid
        begin
            int k = 0;
            while (!imem_rvalid && k < 20) begin
                tick();
                k++;
            end
            if (!imem_rvalid) timeout("wait rvalid");
        end
        pcjump = 1'b1; jalr = 1'b0; ex_pc = 32'h400; imm = 32'h10;
        tick();
        pcjump = 1'b0;
        check("wait-jump no valid", if_valid, 1'b0);
        check("wait-jump req", imem_req, 1'b1);
        check("wait-jump addr", imem_addr, 32'h410);
        wait_valid("wait-jump fetch");
        check("wait-jump if_pc", if_pc, 32'h410);

        // redirect vectors applied while decode is stalled in HOLD
        fixed_data = 1'b0;
        id_ready = 1'b0;
        for (int v = 0; v < 8; v++) begin
            wait_valid("tbl hold");
            p = if_pc;
            ins = if_instr;
            repeat (5) begin
                tick();
                check("tbl hold valid", if_valid, 1'b1);
                check("tbl hold pc", if_pc, p);
                check("tbl hold instr", if_instr, ins);
                check("tbl hold req", imem_req, 1'b0);
            end
            pcjump = 1'b1; jalr = vecs[v].jalr; ex_pc = vecs[v].ex_pc;
            rs1data = vecs[v].rs1; imm = vecs[v].imm;
            tick();
            pcjump = 1'b0;
            check("tbl misaligned", misaligned, vecs[v].exp_mis);
            if (vecs[v].exp_mis) begin
                check("tbl badaddr", badaddr, vecs[v].exp_tgt);
                check("tbl mis keeps valid", if_valid, 1'b1);
                check("tbl mis keeps pc", if_pc, p);
                nxt = p + 32'd4;
            end else begin
                check("tbl jump clears valid", if_valid, 1'b0);
                check("tbl jump req", imem_req, 1'b1);
                check("tbl jump addr", imem_addr, vecs[v].exp_tgt);
                nxt = vecs[v].exp_tgt;
            end
            id_ready = 1'b1;
            tick();
            id_ready = 1'b0;
            check("tbl mis pulse", misaligned, 1'b0);
            wait_valid("tbl next");
            check("tbl next pc", if_pc, nxt);
            check("tbl next instr", if_instr, mem_word(nxt));
        end

        // asynchronous reset while a fetch is outstanding
        id_ready = 1'b1;
        lat_max = 3;
        begin
            int k = 0;
            while (!(imem_req && imem_ready) && k < 60) begin
                tick();
                k++;
            end
            if (!(imem_req && imem_ready)) timeout("reach req");
        end
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("async req", imem_req, 1'b0);
        check("async addr", imem_addr, 32'h100);
        check("async if_valid", if_valid, 1'b0);
        check("async if_instr", if_instr, 32'h0);
        check("async if_pc", if_pc, 32'h0);
        check("async misaligned", misaligned, 1'b0);
        check("async badaddr", badaddr, 32'h0);

        // randomized traffic against an instruction-stream model
        ready_pct = 70;
        assert_reset();
        release_reset();
        exp_pc = 32'h100;
        delivered = 0;
        for (int i = 0; i < 3000; i++) begin
            id_ready = ($urandom_range(3, 0) != 0);
            pcjump   = ($urandom_range(15, 0) == 0);
            jalr     = $urandom_range(1, 0);
            ex_pc    = $urandom & 32'hFFFF_FFFC;
            rs1data  = ($urandom & 32'hFFFF_FFFC) | 32'($urandom_range(1, 0));
            imm      = ($urandom & 32'h0000_FFFC) | (($urandom_range(4, 0) == 0) ? 32'h2 : 32'h0);
            if (if_valid && id_ready) begin
                check("rand if_pc", if_pc, exp_pc);
                check("rand if_instr", if_instr, mem_word(exp_pc));
                exp_pc += 4;
                delivered++;
            end
            t = ref_tgt(jalr, ex_pc, rs1data, imm);
            exp_mis = pcjump && t[1];
            if (pcjump && !t[1]) exp_pc = t;
            chk = imem_req && !imem_ready;
            hold_addr = imem_addr;
            tick();
            pcjump = 1'b0;
            check("rand misaligned", misaligned, exp_mis);
            if (exp_mis) check("rand badaddr", badaddr, t);
            if (chk && imem_req) check("rand addr stable", imem_addr, hold_addr);
        end
        check("rand progress", delivered >= 100, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
